// File: rtl/top_uart_tx_app.sv
// top_uart_tx_app: four push-buttons, each press sends "BTN<k>" as 8N1 UART.
// Optional build macro TOP_UART_TX_APP_CRLF_EN appends CR LF (6-byte message
// instead of 4).
// Trigger path: 2-flop sync -> registered rising edge -> priority capture ->
// FSM start, so the start bit appears on the 4th edge after the first edge
// that samples the button high.

// Per-button lane: synchronizer, arm flag and registered rising-edge pulse.
module top_uart_tx_app_btn_lane (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic settled_i,
  output logic rise_o
);
  logic s1, s2, s3, armed;

  // A lane only arms after its synchronized level has been seen low, so a
  // button held through reset cannot fake a 0->1 transition on release of rst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      armed  <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      s1     <= btn_i;
      s2     <= s1;
      s3     <= s2;
      armed  <= armed | (settled_i & ~s2);
      rise_o <= s2 & ~s3 & armed;
    end
  end
endmodule

module top_uart_tx_app #(
  parameter int DEFAULT_SEND_RATE = 750000,
  parameter int DEFAULT_CLOCK_IN  = 10000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] button_i,
  output logic       uart_tx_data_o,
  output logic       uart_tx_active_o
);
  localparam int NUM_LANES    = 4;
  localparam int CLKS_PER_BIT = (DEFAULT_CLOCK_IN * 1000) / DEFAULT_SEND_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
`ifdef TOP_UART_TX_APP_CRLF_EN
  localparam int MSG_LEN = 6;
`else
  localparam int MSG_LEN = 4;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t              state, state_n;
  logic [CNT_W-1:0]       clk_cnt, clk_n;
  logic [2:0]             bit_cnt, bit_n;
  logic [2:0]             byte_cnt, byte_n;
  logic                   data_n;
  logic [7:0]             cur_byte;
  logic [1:0]             settle_cnt;
  logic [NUM_LANES-1:0]   rise;
  logic [1:0]             win_idx;
  logic                   pend_vld;
  logic [1:0]             pend_idx;

  // Message byte idx for button k.
  function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [1:0] k);
    case (idx)
      3'd0:    msg_byte = 8'h42;
      3'd1:    msg_byte = 8'h54;
      3'd2:    msg_byte = 8'h4E;
`ifdef TOP_UART_TX_APP_CRLF_EN
      3'd4:    msg_byte = 8'h0D;
      3'd5:    msg_byte = 8'h0A;
`endif
      default: msg_byte = 8'h30 + {6'd0, k};
    endcase
  endfunction

  // Synchronizer outputs are meaningless for the first two edges after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)               settle_cnt <= 2'd0;
    else if (!settle_cnt[1]) settle_cnt <= settle_cnt + 2'd1;
  end

  top_uart_tx_app_btn_lane u_lane [NUM_LANES-1:0] (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .btn_i     (button_i),
    .settled_i (settle_cnt[1]),
    .rise_o    (rise)
  );

  // Lowest button index wins when several edges land together.
  always_comb begin
    win_idx = 2'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (rise[i]) win_idx = 2'(i);
  end

  // Capture one trigger while idle; edges seen while busy are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_vld <= 1'b0;
      pend_idx <= 2'd0;
    end else if (pend_vld) begin
      pend_vld <= 1'b0;
    end else if (state == IDLE && |rise) begin
      pend_vld <= 1'b1;
      pend_idx <= win_idx;
    end
  end

  // FSM, counters and registered line/active outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      clk_cnt          <= '0;
      bit_cnt          <= 3'd0;
      byte_cnt         <= 3'd0;
      uart_tx_data_o   <= 1'b1;
      uart_tx_active_o <= 1'b0;
    end else begin
      state            <= state_n;
      clk_cnt          <= clk_n;
      bit_cnt          <= bit_n;
      byte_cnt         <= byte_n;
      uart_tx_data_o   <= data_n;
      uart_tx_active_o <= (state_n != IDLE);
    end
  end

  // Next-state: bit timing, bit/byte sequencing, and the next line level.
  always_comb begin
    state_n  = state;
    clk_n    = clk_cnt;
    bit_n    = bit_cnt;
    byte_n   = byte_cnt;
    data_n   = 1'b1;
    cur_byte = 8'h00;
    case (state)
      IDLE: if (pend_vld) begin
        state_n = START;
        clk_n   = '0;
        bit_n   = 3'd0;
        byte_n  = 3'd0;
      end
      START: if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
        clk_n   = '0;
        bit_n   = 3'd0;
        state_n = DATA;
      end else clk_n = clk_cnt + 1'b1;
      DATA: if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
        clk_n = '0;
        if (bit_cnt == 3'd7) state_n = STOP;
        else                 bit_n   = bit_cnt + 3'd1;
      end else clk_n = clk_cnt + 1'b1;
      STOP: if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
        clk_n = '0;
        if (byte_cnt == 3'(MSG_LEN - 1)) state_n = IDLE;
        else begin
          byte_n  = byte_cnt + 3'd1;
          state_n = START;
        end
      end else clk_n = clk_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   data_n = 1'b0;
      DATA: begin
        cur_byte = msg_byte(byte_n, pend_idx);
        data_n   = cur_byte[bit_n];
      end
      default: data_n = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_top_uart_tx_app.sv
// Bench for top_uart_tx_app: a UART decoder on the line, a string-level
// message model, a vector table, random presses and corner-case sequences.
module tb_top_uart_tx_app;
  localparam int CPB = 13;
`ifdef TOP_UART_TX_APP_CRLF_EN
  localparam int MSG_LEN = 6;
`else
  localparam int MSG_LEN = 4;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] button_i = 4'd0;
  logic       uart_tx_data_o;
  logic       uart_tx_active_o;

  top_uart_tx_app #(.DEFAULT_SEND_RATE(750000), .DEFAULT_CLOCK_IN(10000)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .button_i         (button_i),
    .uart_tx_data_o   (uart_tx_data_o),
    .uart_tx_active_o (uart_tx_active_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: decodes 8N1 frames sampled mid-bit, counts active pulses.
  byte unsigned rx_q[$];
  int   act_rises = 0, idle_viol = 0, frame_err = 0, rx_cnt = 0;
  logic act_prev = 1'b0, rx_busy = 1'b0, mon_en = 1'b0;
  logic [7:0] rx_sh = 8'h00;

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        rx_busy  = 1'b0;
        act_prev = 1'b0;
      end else if (mon_en) begin
        if (uart_tx_active_o && !act_prev) act_rises++;
        act_prev = uart_tx_active_o;
        if (!uart_tx_active_o && uart_tx_data_o !== 1'b1) idle_viol++;
        if (!rx_busy) begin
          if (uart_tx_data_o === 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt % CPB == 6) begin
            if (rx_cnt / CPB == 0) begin
              if (uart_tx_data_o !== 1'b0) frame_err++;
            end else if (rx_cnt / CPB <= 8) begin
              rx_sh[rx_cnt / CPB - 1] = uart_tx_data_o;
            end else begin
              if (uart_tx_data_o !== 1'b1) frame_err++;
              rx_q.push_back(rx_sh);
              rx_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  // Reference: the message is simply the text "BTN<k>" (plus CR LF).
  function automatic string exp_msg(input int k);
    string e;
    e = $sformatf("BTN%0d", k);
`ifdef TOP_UART_TX_APP_CRLF_EN
    e = {e, "\015\012"};
`endif
    return e;
  endfunction

  function automatic int lowest_btn(input logic [3:0] b);
    int k = -1;
    for (int j = 3; j >= 0; j--) if (b[j]) k = j;
    return k;
  endfunction

  // Press b, optionally press mid_b 100 cycles into the message, wait for the
  // message to finish, then compare timing and decoded bytes.
  task automatic run_msg(input logic [3:0] b, input int k, input string tag,
                         input logic [3:0] mid_b, input bit release_btn);
    string e;
    int lat, len;
    e = exp_msg(k);
    rx_q.delete();
    button_i = b;
    lat = 0;
    do begin @(negedge clk_i); lat++; end while (!uart_tx_active_o && lat < 20);
    chk({tag, " start_latency"}, lat, 5);
    if (!uart_tx_active_o) begin button_i = 4'd0; return; end
    len = 0;
    while (uart_tx_active_o && len < 3000) begin
      @(negedge clk_i);
      len++;
      if (len == 100 && mid_b != 4'd0) button_i = mid_b;
    end
    chk({tag, " active_len"}, len, MSG_LEN * 10 * CPB);
    chk({tag, " byte_count"}, rx_q.size(), MSG_LEN);
    for (int i = 0; i < MSG_LEN && i < rx_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), rx_q[i], e[i]);
    if (release_btn) begin
      button_i = 4'd0;
      repeat (16) @(negedge clk_i);
    end
  endtask

  typedef struct {
    logic [3:0] btn;
    int         digit;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, k;
    logic [3:0] b;

    tbl[0] = '{4'b0001, 0}; tbl[1] = '{4'b0010, 1};
    tbl[2] = '{4'b0100, 2}; tbl[3] = '{4'b1000, 3};
    tbl[4] = '{4'b0011, 0}; tbl[5] = '{4'b1100, 2};
    tbl[6] = '{4'b1111, 0}; tbl[7] = '{4'b0110, 1};

    // Reset held 16 cycles: line idle high, inactive, and still so after.
    @(posedge clk_i);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      chk($sformatf("reset_hold%0d", i), {uart_tx_data_o, uart_tx_active_o}, 2'b10);
    end
    rst_i = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      chk($sformatf("post_reset%0d", i), {uart_tx_data_o, uart_tx_active_o}, 2'b10);
    end

    // Table: single and simultaneous presses, priority to the lowest index.
    for (int i = 0; i < 8; i++)
      run_msg(tbl[i].btn, tbl[i].digit, $sformatf("vec%0d", i), 4'd0, 1'b1);

    // Held button must not retrigger.
    run_msg(4'b0001, 0, "hold", 4'd0, 1'b0);
    r0 = act_rises;
    repeat (1000) @(negedge clk_i);
    chk("hold no_retrigger", act_rises - r0, 0);
    chk("hold line_high", uart_tx_data_o, 1'b1);
    chk("hold no_new_bytes", rx_q.size(), MSG_LEN);
    button_i = 4'd0;
    repeat (16) @(negedge clk_i);

    // Press while busy is dropped, not queued.
    run_msg(4'b0001, 0, "busy", 4'b0100, 1'b0);
    r0 = act_rises;
    repeat (300) @(negedge clk_i);
    chk("busy not_queued", act_rises - r0, 0);
    button_i = 4'd0;
    repeat (16) @(negedge clk_i);

    // Reset during the second byte aborts; held button does not restart.
    rx_q.delete();
    button_i = 4'b0010;
    r0 = 0;
    while (rx_q.size() < 1 && r0 < 400) begin @(negedge clk_i); r0++; end
    chk("midreset first_byte", rx_q.size(), 1);
    repeat (20) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midreset abort", {uart_tx_data_o, uart_tx_active_o}, 2'b10);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    r0 = act_rises;
    repeat (500) @(negedge clk_i);
    chk("midreset no_resume", act_rises - r0, 0);
    chk("midreset no_bytes", rx_q.size(), 1);
    button_i = 4'd0;
    repeat (16) @(negedge clk_i);
    run_msg(4'b0010, 1, "after_reset", 4'd0, 1'b1);

    // Random presses against the string model.
    for (int i = 0; i < 6; i++) begin
      b = 4'($urandom_range(1, 15));
      k = lowest_btn(b);
      run_msg(b, k, $sformatf("rand%0d_b%0h", i, b), 4'd0, 1'b1);
      repeat ($urandom_range(0, 24)) @(negedge clk_i);
    end

    chk("idle_line_high", idle_viol, 0);
    chk("frame_errors", frame_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
